// File: rtl/nvram_upload.sv
// Upload-side ioctl responder: answers HPS read strobes with bytes fetched from a core RAM port,
// pausing the core CPU for the session. Optional `NVRAM_UPLOAD_CHECKSUM_EN adds a running-sum byte at SIZE.
module nvram_upload #(
  parameter int          AW     = 11,
  parameter int          SIZE   = 2048,
  parameter int          RD_LAT = 1,
  parameter logic [7:0]  FILL   = 8'hFF
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_dout,
  output logic          upload_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE,
    S_READY,
    S_FETCH,
    S_DONE
  } state_t;

  localparam logic [24:0] ADDR_SIZE = 25'(SIZE);
  localparam logic [2:0]  LAT_LAST  = 3'(RD_LAT);

  state_t        state_q, state_d;
  logic [2:0]    lat_cnt_q, lat_cnt_d;
  logic [7:0]    din_q, din_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_rd_q, ram_rd_d;
  logic          in_range;
  logic          accept;
  logic          capture;
  logic [7:0]    oor_byte;

`ifdef NVRAM_UPLOAD_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  function automatic logic [7:0] neg8(input logic [7:0] s);
    return 8'h00 - s;
  endfunction
`endif

  assign in_range = (ioctl_addr < ADDR_SIZE);
  assign accept   = (state_q == S_READY) && ioctl_upload && ioctl_rd;
  assign capture  = (state_q == S_FETCH) && ioctl_upload && (lat_cnt_q == LAT_LAST);

`ifdef NVRAM_UPLOAD_CHECKSUM_EN
  assign oor_byte = (ioctl_addr == ADDR_SIZE) ? neg8(sum_q) : FILL;
`else
  assign oor_byte = FILL;
`endif

  // State register and datapath flops
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lat_cnt_q  <= 3'd0;
      din_q      <= 8'h00;
      ram_addr_q <= '0;
      ram_rd_q   <= 1'b0;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
      sum_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      din_q      <= din_d;
      ram_addr_q <= ram_addr_d;
      ram_rd_q   <= ram_rd_d;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // Next-state: a dropped upload ends the session from any active state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ioctl_upload) state_d = S_PAUSE;
      S_PAUSE: begin
        if (!ioctl_upload)  state_d = S_DONE;
        else if (pause_ack) state_d = S_READY;
      end
      S_READY: begin
        if (!ioctl_upload)              state_d = S_DONE;
        else if (ioctl_rd && in_range) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (!ioctl_upload)                state_d = S_DONE;
        else if (lat_cnt_q == LAT_LAST) state_d = S_READY;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: RAM request, returned byte, latency count
  always_comb begin
    lat_cnt_d  = (state_q == S_FETCH) ? lat_cnt_q + 3'd1 : 3'd0;
    din_d      = din_q;
    ram_addr_d = ram_addr_q;
    ram_rd_d   = 1'b0;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
    sum_d      = sum_q;
    if (state_q == S_IDLE && ioctl_upload) sum_d = 8'h00;
`endif
    if (accept) begin
      if (in_range) begin
        ram_addr_d = ioctl_addr[AW-1:0];
        ram_rd_d   = 1'b1;
      end else begin
        din_d = oor_byte;
      end
    end
    if (capture) begin
      din_d = ram_dout;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
      sum_d = sum_q + ram_dout;
`endif
    end
  end

  // Outputs decoded from state; DONE keeps pause_req so it drops one cycle after the pulse
  always_comb begin
    pause_req   = (state_q == S_PAUSE) || (state_q == S_READY) ||
                  (state_q == S_FETCH) || (state_q == S_DONE);
    ioctl_wait  = (state_q == S_PAUSE) || (state_q == S_FETCH);
    upload_done = (state_q == S_DONE);
    ioctl_din   = din_q;
    ram_addr    = ram_addr_q;
    ram_rd      = ram_rd_q;
  end

endmodule

// File: tb/tb_nvram_upload.sv
// Self-checking bench for nvram_upload: RAM model with RD_LAT latency, byte-level reference model,
// directed timing scenarios plus randomized address streams.
module tb_nvram_upload;
  localparam int         AW     = 11;
  localparam int         SIZE   = 2048;
  localparam int         RD_LAT = 2;
  localparam logic [7:0] FILL   = 8'hFF;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic          clk_sys;
  logic          reset;
  logic          ioctl_upload;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic          pause_req;
  logic          pause_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [7:0]    ram_dout;
  logic          upload_done;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [7:0] tb_sum = 8'h00;

  nvram_upload #(.AW(AW), .SIZE(SIZE), .RD_LAT(RD_LAT), .FILL(FILL)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .pause_req(pause_req), .pause_ack(pause_ack), .ram_addr(ram_addr), .ram_rd(ram_rd),
    .ram_dout(ram_dout), .upload_done(upload_done)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // RAM: data valid exactly RD_LAT cycles after ram_rd, junk otherwise
  logic [7:0] mem [0:SIZE-1];
  logic [7:0] dpipe [0:3];
  logic [3:0] vpipe = 4'b0000;
  logic [7:0] junk  = 8'h00;
  always @(posedge clk_sys) begin
    dpipe[0] <= mem[ram_addr];
    for (int k = 1; k < 4; k++) dpipe[k] <= dpipe[k-1];
    vpipe <= {vpipe[2:0], ram_rd};
    junk  <= 8'($urandom);
  end
  assign ram_dout = vpipe[RD_LAT-1] ? dpipe[RD_LAT-1] : junk;

  task automatic tick();
    @(posedge clk_sys);
    #1;
    cyc++;
  endtask

  // Reference: what the HPS should receive for a read of address a
  function automatic logic [7:0] model_read(input logic [24:0] a);
    logic [7:0] b;
    if (a < 25'(SIZE)) begin
      b = mem[a[AW-1:0]];
      tb_sum = tb_sum + b;
    end else if (CK_EN && a == 25'(SIZE)) begin
      b = 8'h00 - tb_sum;
    end else begin
      b = FILL;
    end
    return b;
  endfunction

  task automatic start_session();
    ioctl_upload = 1'b1;
    pause_ack    = 1'b0;
    tick();
    pause_ack = 1'b1;
    tick();
    tb_sum = 8'h00;
  endtask

  task automatic end_session();
    ioctl_upload = 1'b0;
    tick();
    pause_ack = 1'b0;
    tick();
    tick();
  endtask

  // One HPS read; reports returned byte, cycles with wait high, ram_rd pulses, address seen
  task automatic xact(input logic [24:0] a, output logic [7:0] d, output int nwait,
                      output int nrd, output logic [AW-1:0] ra);
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    tick();
    ioctl_rd = 1'b0;
    nwait = 0;
    nrd   = ram_rd ? 1 : 0;
    ra    = ram_addr;
    while (ioctl_wait && nwait < 20) begin
      nwait++;
      tick();
      if (ram_rd) nrd++;
    end
    d = ioctl_din;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({ioctl_din, ioctl_wait, pause_req, ram_rd, ram_addr, upload_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: din=%h wait=%b preq=%b rd=%b addr=%h done=%b, required all zero",
               ioctl_din, ioctl_wait, pause_req, ram_rd, ram_addr, upload_done);
    end
    reset = 1'b0;
    tick();
    n_chk++;
    if ({pause_req, ioctl_wait, upload_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: preq/wait/done=%b required 000",
               {pause_req, ioctl_wait, upload_done});
    end
  endtask

  task automatic test_pause();
    ioctl_upload = 1'b1;
    pause_ack    = 1'b0;
    n_chk++;
    if (pause_req !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_early: pause_req=%b required 0", pause_req);
    end
    tick();
    for (int i = 0; i < 20; i++) begin
      n_chk++;
      if ({pause_req, ioctl_wait, ram_rd} !== 3'b110) begin
        n_fail++;
        $display("FAIL pause_hold[%0d]: preq/wait/rd=%b required 110", i, {pause_req, ioctl_wait, ram_rd});
      end
      ioctl_rd   = (i == 5);
      ioctl_addr = 25'h5;
      tick();
    end
    ioctl_rd  = 1'b0;
    pause_ack = 1'b1;
    tick();
    tb_sum = 8'h00;
    n_chk++;
    if ({pause_req, ioctl_wait, ram_rd} !== 3'b100) begin
      n_fail++;
      $display("FAIL pause_grant: preq/wait/rd=%b required 100", {pause_req, ioctl_wait, ram_rd});
    end
  endtask

  task automatic test_inrange_timing();
    logic [7:0] exp;
    mem[5] = 8'hA5;
    exp = model_read(25'h5);
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'h5;
    tick();
    ioctl_rd = 1'b0;
    n_chk++;
    if (ram_rd !== 1'b1 || ram_addr !== 11'h005 || ioctl_wait !== 1'b1) begin
      n_fail++;
      $display("FAIL inrange_req: rd=%b addr=%h wait=%b required 1 005 1", ram_rd, ram_addr, ioctl_wait);
    end
    for (int k = 1; k <= RD_LAT; k++) begin
      tick();
      n_chk++;
      if (ram_rd !== 1'b0 || ioctl_wait !== 1'b1) begin
        n_fail++;
        $display("FAIL inrange_wait[%0d]: rd=%b wait=%b required 0 1", k, ram_rd, ioctl_wait);
      end
    end
    tick();
    n_chk++;
    if (ioctl_wait !== 1'b0 || ioctl_din !== exp) begin
      n_fail++;
      $display("FAIL inrange_data: wait=%b din=%h required 0 %h", ioctl_wait, ioctl_din, exp);
    end
    end_session();
  endtask

  task automatic test_out_of_range();
    start_session();
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'h1000;
    tick();
    ioctl_rd = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (ioctl_din !== FILL || ioctl_wait !== 1'b0 || ram_rd !== 1'b0) begin
        n_fail++;
        $display("FAIL oor[%0d]: din=%h wait=%b rd=%b required %h 0 0", k, ioctl_din, ioctl_wait, ram_rd, FILL);
      end
      tick();
    end
    end_session();
  endtask

  task automatic test_sequential();
    logic [7:0] d, exp;
    logic [AW-1:0] ra;
    int nw, nr;
    for (int i = 0; i < SIZE; i++) mem[i] = 8'(i);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) mem[0] = 8'h01;
      start_session();
      for (int i = 0; i < SIZE; i++) begin
        exp = model_read(25'(i));
        xact(25'(i), d, nw, nr, ra);
        n_chk++;
        if (d !== exp || nw != RD_LAT + 1 || nr != 1 || ra !== AW'(i)) begin
          n_fail++;
          $display("FAIL seq[%0d]: din=%h wait=%0d rd=%0d addr=%h required %h %0d 1 %h",
                   i, d, nw, nr, ra, exp, RD_LAT + 1, AW'(i));
        end
      end
      exp = (pass == 0) ? (CK_EN ? 8'h00 : FILL) : 8'hFF;
      xact(25'(SIZE), d, nw, nr, ra);
      n_chk++;
      if (d !== exp || nw != 0 || nr != 0) begin
        n_fail++;
        $display("FAIL checksum_read pass%0d: din=%h wait=%0d rd=%0d required %h 0 0", pass, d, nw, nr, exp);
      end
      xact(25'(SIZE + 1), d, nw, nr, ra);
      n_chk++;
      if (d !== FILL || nw != 0 || nr != 0) begin
        n_fail++;
        $display("FAIL above_size pass%0d: din=%h wait=%0d rd=%0d required %h 0 0", pass, d, nw, nr, FILL);
      end
      end_session();
    end
  endtask

  task automatic test_random();
    logic [7:0] d, exp;
    logic [AW-1:0] ra;
    logic [24:0] a;
    int nw, nr, kind;
    bit inr;
    for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
    start_session();
    for (int t = 0; t < 300; t++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0, 1:    a = 25'($urandom_range(0, SIZE - 1));
        2:       a = 25'(SIZE);
        3:       a = 25'($urandom_range(SIZE + 1, 25'h1FFFFFF));
        default: a = {14'($urandom_range(1, 16383)), 11'($urandom_range(0, 31))};
      endcase
      pause_ack = 1'($urandom_range(0, 1));
      inr = (a < 25'(SIZE));
      exp = model_read(a);
      xact(a, d, nw, nr, ra);
      n_chk++;
      if (d !== exp || nw != (inr ? RD_LAT + 1 : 0) || nr != (inr ? 1 : 0) ||
          (inr && ra !== a[AW-1:0])) begin
        n_fail++;
        $display("FAIL rand[%0d] addr=%h: din=%h wait=%0d rd=%0d ramaddr=%h required din=%h",
                 t, a, d, nw, nr, ra, exp);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    end_session();
  endtask

  task automatic test_abort();
    logic [7:0] d, dprev;
    logic [AW-1:0] ra;
    int nw, nr;
    start_session();
    xact(25'h1000, d, nw, nr, ra);
    dprev = ioctl_din;
    mem[7] = 8'h3C;
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'h7;
    tick();
    ioctl_rd     = 1'b0;
    ioctl_upload = 1'b0;
    n_chk++;
    if (ram_rd !== 1'b1 || ioctl_wait !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_req: rd=%b wait=%b required 1 1", ram_rd, ioctl_wait);
    end
    tick();
    n_chk++;
    if ({upload_done, pause_req, ram_rd} !== 3'b110 || ioctl_din !== dprev) begin
      n_fail++;
      $display("FAIL abort_done: done/preq/rd=%b din=%h required 110 %h",
               {upload_done, pause_req, ram_rd}, ioctl_din, dprev);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_chk++;
      if ({upload_done, pause_req, ram_rd, ioctl_wait} !== 4'b0000 || ioctl_din !== dprev) begin
        n_fail++;
        $display("FAIL abort_idle[%0d]: done/preq/rd/wait=%b din=%h required 0000 %h",
                 k, {upload_done, pause_req, ram_rd, ioctl_wait}, ioctl_din, dprev);
      end
    end
    pause_ack = 1'b0;
  endtask

  task automatic test_reset_fetch();
    logic [7:0] d;
    logic [AW-1:0] ra;
    int nw, nr;
    start_session();
    xact(25'h1000, d, nw, nr, ra);
    mem[3] = 8'h77;
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'h3;
    tick();
    ioctl_rd     = 1'b0;
    reset        = 1'b1;
    ioctl_upload = 1'b0;
    pause_ack    = 1'b0;
    tick();
    n_chk++;
    if ({ioctl_din, ioctl_wait, pause_req, ram_rd, ram_addr, upload_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_fetch: din=%h wait=%b preq=%b rd=%b addr=%h done=%b required all zero",
               ioctl_din, ioctl_wait, pause_req, ram_rd, ram_addr, upload_done);
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_chk++;
      if ({upload_done, pause_req, ioctl_din} !== 10'h000) begin
        n_fail++;
        $display("FAIL reset_fetch_after[%0d]: done=%b preq=%b din=%h required 0 0 00",
                 k, upload_done, pause_req, ioctl_din);
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    ioctl_upload = 1'b0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;
    pause_ack    = 1'b0;
    for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
    test_reset();
    test_pause();
    test_inrange_timing();
    test_out_of_range();
    test_sequential();
    test_random();
    test_abort();
    test_reset_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
